rxepktctl: RTL

// Per-packet receive check controller. It sits after the RX byte stream and its

---
 rtl/rxepktctl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/rxepktctl.sv
// ----------------------------------------------------------------------------
// rxepktctl -- per-packet receive check controller
//
// Gathers checker error flags across each received packet, bounds the packet
// length and, at end of packet, issues one commit/drop command to the RX
// packet buffer over a valid/ready handshake. Checker enables are shadowed
// so they only change between packets.
//
// Optional feature: define RXEPKTCTL_STATS_EN to build the 16-bit saturating
// committed/dropped packet counters; otherwise both outputs are tied to 0.
//
// Ports:
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_ce                   byte strobe; stream state advances only when set
//   i_v                    byte valid, high for the whole packet
//   i_chk_err[NCHK]        checker error flags
//   i_cfg_wr, i_cfg_data   enable-mask write port (into shadow register)
//   o_chk_en[NCHK]         per-checker enable, stable within a packet
//   o_cmd_valid/i_cmd_ready command handshake to the packet buffer
//   o_cmd_commit           1 = keep packet, 0 = drop
//   o_cmd_len[LGLEN]       saturated byte count of the packet
//   o_cmd_why[NCHK+2]      {overrun, length bad, accumulated checker errors}
//   o_pkt_cnt, o_drop_cnt  committed / dropped packet counters
// ----------------------------------------------------------------------------
module rxepktctl #(
   parameter int NCHK   = 3,
   parameter int LGLEN  = 11,
   parameter int MINLEN = 64,
   parameter int MAXLEN = 1518
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_ce,
   input  logic              i_v,
   input  logic [NCHK-1:0]   i_chk_err,
   input  logic              i_cfg_wr,
   input  logic [NCHK-1:0]   i_cfg_data,
   output logic [NCHK-1:0]   o_chk_en,
   output logic              o_cmd_valid,
   input  logic              i_cmd_ready,
   output logic              o_cmd_commit,
   output logic [LGLEN-1:0]  o_cmd_len,
   output logic [NCHK+1:0]   o_cmd_why,
   output logic [15:0]       o_pkt_cnt,
   output logic [15:0]       o_drop_cnt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RECV = 2'd1;
   localparam logic [1:0] S_CMD  = 2'd2;
   localparam logic [1:0] S_DISC = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [LGLEN-1:0] len_q, len_d;
   logic [NCHK-1:0]  err_q, err_d;
   logic             armed_q, armed_d;     // a !i_v slot was seen since reset
   logic             ov_q, ov_d;           // packet overran a pending command
   logic             ov_end_q, ov_end_d;   // ...and that packet already ended
   logic [NCHK-1:0]  shadow_q, shadow_d;
   logic [NCHK-1:0]  chk_en_q, chk_en_d;
   logic             valid_q, valid_d;
   logic             commit_q, commit_d;
   logic [LGLEN-1:0] cmd_len_q, cmd_len_d;
   logic [NCHK+1:0]  why_q, why_d;

   logic [NCHK-1:0]  err_nxt;
   logic [LGLEN-1:0] len_inc;
   logic             len_bad;
   logic             accept;
   logic             issue_drop;

   // Checker flags for a byte land one slot later, so they are folded in on
   // every RECV strobe including the first slot after the packet.
   assign err_nxt = err_q | (i_chk_err & chk_en_q);
   assign len_inc = (len_q == '1) ? len_q : len_q + 1'b1;
   assign len_bad = (len_q < LGLEN'(MINLEN)) || (len_q > LGLEN'(MAXLEN));
   assign accept  = (state_q == S_CMD) && valid_q && i_cmd_ready;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case statement can infer a latch.
      state_d    = state_q;
      len_d      = len_q;
      err_d      = err_q;
      armed_d    = armed_q;
      ov_d       = ov_q;
      ov_end_d   = ov_end_q;
      chk_en_d   = chk_en_q;
      valid_d    = valid_q;
      commit_d   = commit_q;
      cmd_len_d  = cmd_len_q;
      why_d      = why_q;
      issue_drop = 1'b0;
      shadow_d   = i_cfg_wr ? i_cfg_data : shadow_q;

      case (state_q)
         S_IDLE: begin
            if (!i_v) chk_en_d = shadow_q;
            if (i_ce) begin
               if (!i_v) begin
                  armed_d = 1'b1;
               end else if (armed_q) begin
                  state_d = S_RECV;
                  len_d   = LGLEN'(1);
                  err_d   = '0;
               end
            end
         end
         S_RECV: begin
            if (i_ce) begin
               err_d = err_nxt;
               if (i_v) begin
                  len_d = len_inc;
               end else begin
                  cmd_len_d = len_q;
                  commit_d  = (err_nxt == '0) && !len_bad;
                  why_d     = {1'b0, len_bad, err_nxt};
                  valid_d   = 1'b1;
                  state_d   = S_CMD;
               end
            end
         end
         S_CMD: begin
            if (accept) begin
               valid_d  = 1'b0;
               ov_d     = 1'b0;
               ov_end_d = 1'b0;
               if (ov_q) begin
                  // Overrun packet already finished: report it straight away
                  // instead of waiting in DISCARD for an end that has passed.
                  if (ov_end_q || (i_ce && !i_v)) issue_drop = 1'b1;
                  else                            state_d    = S_DISC;
               end else if (i_ce && i_v) begin
                  state_d = S_RECV;
                  len_d   = LGLEN'(1);
                  err_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (i_ce) begin
               if (i_v) begin
                  ov_d     = 1'b1;
                  ov_end_d = 1'b0;
               end else if (ov_q) begin
                  ov_end_d = 1'b1;
               end
            end
         end
         default: begin  // S_DISC
            if (i_ce && !i_v) issue_drop = 1'b1;
         end
      endcase

      if (issue_drop) begin
         valid_d   = 1'b1;
         commit_d  = 1'b0;
         cmd_len_d = '0;
         why_d     = {1'b1, {(NCHK+1){1'b0}}};
         state_d   = S_CMD;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the same pre-edge values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         err_q     <= '0;
         armed_q   <= 1'b0;
         ov_q      <= 1'b0;
         ov_end_q  <= 1'b0;
         shadow_q  <= '1;
         chk_en_q  <= '1;
         valid_q   <= 1'b0;
         commit_q  <= 1'b0;
         cmd_len_q <= '0;
         why_q     <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         err_q     <= err_d;
         armed_q   <= armed_d;
         ov_q      <= ov_d;
         ov_end_q  <= ov_end_d;
         shadow_q  <= shadow_d;
         chk_en_q  <= chk_en_d;
         valid_q   <= valid_d;
         commit_q  <= commit_d;
         cmd_len_q <= cmd_len_d;
         why_q     <= why_d;
      end
   end

   assign o_chk_en     = chk_en_q;
   assign o_cmd_valid  = valid_q;
   assign o_cmd_commit = commit_q;
   assign o_cmd_len    = cmd_len_q;
   assign o_cmd_why    = why_q;

`ifdef RXEPKTCTL_STATS_EN
   logic [15:0] pkt_cnt_q, drop_cnt_q;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else if (accept) begin
         if (commit_q && pkt_cnt_q != '1)        pkt_cnt_q  <= pkt_cnt_q + 16'd1;
         else if (!commit_q && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign o_pkt_cnt  = pkt_cnt_q;
   assign o_drop_cnt = drop_cnt_q;
`else
   assign o_pkt_cnt  = 16'd0;
   assign o_drop_cnt = 16'd0;
`endif

endmodule
